// File: rtl/sub_shift_rows.sv
// Byte-serial SubBytes + ShiftRows stage: collects a 16-byte AES state, substituting on capture,
// then replays it row-shifted one byte per cycle. INVERSE selects the decrypt S-box and InvShiftRows.
module sub_shift_rows #(
    parameter bit INVERSE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_en,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_en_q, dout_en_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        wr_en;
    logic [7:0]  buf_q [16];
    logic [7:0]  sub_byte;
    logic [1:0]  row, col, src_col;
    logic [3:0]  src_idx;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply over 8'b11111110); maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            r = gmul(r, r);
            if (i != 7) r = gmul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    assign sub_byte = INVERSE ? sbox_inv(din) : sbox_fwd(din);

    // Output k = (row k%4, col k/4) reads buffer index row + 4*((col +/- row) mod 4).
    assign row     = rd_cnt_q[1:0];
    assign col     = rd_cnt_q[3:2];
    assign src_col = INVERSE ? (col - row) : (col + row);
    assign src_idx = {src_col, row};

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        dout_d    = dout_q;
        dout_en_d = 1'b0;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        unique case (state_q)
            COLLECT: begin
                busy_d = din_en || (wr_cnt_q != 4'd0);
                if (din_en) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + 4'd1;
                    if (wr_cnt_q == 4'd15) begin
                        state_d  = EMIT;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                    end
                end
            end
            EMIT: begin
                dout_d    = buf_q[src_idx];
                dout_en_d = 1'b1;
                busy_d    = 1'b1;
                rd_cnt_d  = rd_cnt_q + 4'd1;
                if (din_en) ovf_d = 1'b1;
                if (rd_cnt_q == 4'd15) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_cnt_q] <= sub_byte;
    end

    assign dout    = dout_q;
    assign dout_en = dout_en_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;

endmodule
